// File: rtl/smi_ctrl_if.sv
// SMI byte bus, frame-buffer write port and swap handshake between the Pi side and smi_ctrl.
interface smi_ctrl_if #(parameter int ADDR_W = 12);
    logic [7:0]        smi_in;
    logic              write;
    logic              read;
    logic [7:0]        smi_out;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_addr;
    logic [7:0]        fb_wdata;
    logic              swap_req;
    logic              swap_ack;
    logic              err;

    modport master (
        output smi_in, write, read, swap_ack,
        input  smi_out, fb_we, fb_addr, fb_wdata, swap_req, err
    );

    modport slave (
        input  smi_in, write, read, swap_ack,
        output smi_out, fb_we, fb_addr, fb_wdata, swap_req, err
    );
endinterface

// File: rtl/smi_ctrl.sv
// Byte-stream command sequencer: frame-buffer writes, status readback, frame swap, stall timeout.
//
// state   | meaning
// IDLE    | waiting for a command byte
// ADDR_H  | expecting address high byte
// ADDR_L  | expecting address low byte
// LEN_H   | expecting length high byte
// LEN_L   | expecting length low byte
// DATA    | each write goes to the frame buffer
// RD_STAT | status byte on smi_out, waiting for read
// RD_CNT  | frame count on smi_out, waiting for read
module smi_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 65536
) (
    input logic       clk,
    input logic       reset_n,
    smi_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ADDR_H  = 3'd1;
    localparam logic [2:0] ADDR_L  = 3'd2;
    localparam logic [2:0] LEN_H   = 3'd3;
    localparam logic [2:0] LEN_L   = 3'd4;
    localparam logic [2:0] DATA    = 3'd5;
    localparam logic [2:0] RD_STAT = 3'd6;
    localparam logic [2:0] RD_CNT  = 3'd7;

    logic [2:0]        state, state_nxt;
    logic [7:0]        smi_out_q, fb_wdata_q, frame_cnt, addr_h, len_h;
    logic [ADDR_W-1:0] fb_addr_q, addr;
    logic [15:0]       rem;
    logic [TW-1:0]     tmo_cnt;
    logic              fb_we_q, swap_req_q, err_q;
    logic              err_set, err_clr, swap_set, ld_stat, ld_cnt, ld_zero, data_wr, tmo_hit;
    logic [15:0]       addr_full, len_full;

    assign addr_full = {addr_h, bus.smi_in};
    assign len_full  = {len_h, bus.smi_in};
    assign tmo_hit   = (state != IDLE) && !bus.write && !bus.read
                       && (tmo_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        err_set   = bus.read & bus.write;
        err_clr   = 1'b0;
        swap_set  = 1'b0;
        ld_stat   = 1'b0;
        ld_cnt    = 1'b0;
        ld_zero   = 1'b0;
        data_wr   = 1'b0;
        if (bus.write) begin
            case (state)
                IDLE: begin
                    case (bus.smi_in)
                        8'h00: ;
                        8'h01: err_clr = 1'b1;
                        8'h40: state_nxt = ADDR_H;
                        8'h80: begin
                            state_nxt = RD_STAT;
                            ld_stat   = 1'b1;
                        end
                        8'hC0: begin
                            if (swap_req_q) err_set  = 1'b1;
                            else            swap_set = 1'b1;
                        end
                        default: err_set = 1'b1;
                    endcase
                end
                ADDR_H: state_nxt = ADDR_L;
                ADDR_L: state_nxt = LEN_H;
                LEN_H:  state_nxt = LEN_L;
                LEN_L:  state_nxt = (len_full == 16'd0) ? IDLE : DATA;
                DATA: begin
                    data_wr = 1'b1;
                    if (rem == 16'd1) state_nxt = IDLE;
                end
                default: begin
                    // a write while a readback is pending is a protocol error
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end else if (bus.read) begin
            case (state)
                RD_STAT: begin
                    ld_cnt    = 1'b1;
                    state_nxt = RD_CNT;
                end
                RD_CNT: begin
                    ld_zero   = 1'b1;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end else if (tmo_hit) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            smi_out_q  <= 8'h00;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= 8'h00;
            swap_req_q <= 1'b0;
            err_q      <= 1'b0;
            frame_cnt  <= 8'h00;
            tmo_cnt    <= '0;
            addr_h     <= 8'h00;
            len_h      <= 8'h00;
            addr       <= '0;
            rem        <= 16'd0;
        end else begin
            state   <= state_nxt;
            err_q   <= (err_q & ~err_clr) | err_set;
            fb_we_q <= data_wr;
            tmo_cnt <= (state == IDLE || bus.write || bus.read || tmo_hit) ? '0 : tmo_cnt + TW'(1);

            if (bus.write && state == ADDR_H) addr_h <= bus.smi_in;
            if (bus.write && state == ADDR_L) addr   <= addr_full[ADDR_W-1:0];
            if (bus.write && state == LEN_H)  len_h  <= bus.smi_in;
            if (bus.write && state == LEN_L)  rem    <= len_full;
            if (data_wr) begin
                fb_addr_q  <= addr;
                fb_wdata_q <= bus.smi_in;
                addr       <= addr + ADDR_W'(1);
                rem        <= rem - 16'd1;
            end

            // the ack path is independent of the command FSM
            if (bus.swap_ack && swap_req_q) begin
                swap_req_q <= 1'b0;
                frame_cnt  <= frame_cnt + 8'd1;
            end else if (swap_set) begin
                swap_req_q <= 1'b1;
            end

            if (ld_stat)      smi_out_q <= {swap_req_q, err_q, 3'b000, state};
            else if (ld_cnt)  smi_out_q <= frame_cnt;
            else if (ld_zero) smi_out_q <= 8'h00;
        end
    end

    assign bus.smi_out  = smi_out_q;
    assign bus.fb_we    = fb_we_q;
    assign bus.fb_addr  = fb_addr_q;
    assign bus.fb_wdata = fb_wdata_q;
    assign bus.swap_req = swap_req_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_smi_ctrl.sv
// Directed bench for smi_ctrl: burst writes, address wrap, swap/status readback, timeout, reset abort.
module tb_smi_ctrl;
    localparam int ADDR_W  = 12;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_err;
    int   we_cnt;

    smi_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    smi_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n)       we_cnt <= 0;
        else if (bus.fb_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.smi_in = b;
        bus.write  = 1'b1;
        @(negedge clk);
        bus.write  = 1'b0;
    endtask

    task automatic rd_pulse();
        @(negedge clk);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        bus.swap_ack = 1'b1;
        @(negedge clk);
        bus.swap_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 16'(bus.fb_we), 16'h1);
        chk({tag, "_addr"}, 16'(bus.fb_addr), a);
        chk({tag, "_data"}, 16'(bus.fb_wdata), 16'(d));
    endtask

    task automatic hdr(input logic [15:0] a, input logic [15:0] l);
        send(8'h40);
        send(a[15:8]);
        send(a[7:0]);
        send(l[15:8]);
        send(l[7:0]);
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        bus.smi_in   = 8'h00;
        bus.write    = 1'b0;
        bus.read     = 1'b0;
        bus.swap_ack = 1'b0;
        #23;
        chk("rst_smi_out", 16'(bus.smi_out), 16'h00);
        chk("rst_fb_we", 16'(bus.fb_we), 16'h0);
        chk("rst_fb_addr", 16'(bus.fb_addr), 16'h000);
        chk("rst_swap_req", 16'(bus.swap_req), 16'h0);
        chk("rst_err", 16'(bus.err), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: three-byte burst at 0x010
        hdr(16'h0010, 16'h0003);
        chk("t1_no_we_hdr", 16'(bus.fb_we), 16'h0);
        send(8'hAA);
        chk_wr("t1_b0", 16'h010, 8'hAA);
        idle(1);
        chk("t1_we_one_cycle", 16'(bus.fb_we), 16'h0);
        send(8'hBB);
        chk_wr("t1_b1", 16'h011, 8'hBB);
        send(8'hCC);
        chk_wr("t1_b2", 16'h012, 8'hCC);
        idle(1);
        chk("t1_state", 16'(dut.state), 16'h0);
        chk("t1_err", 16'(bus.err), 16'h0);
        chk("t1_we_cnt", 16'(we_cnt), 16'd3);

        // 2: address wrap, then zero-length command
        hdr(16'h0FFF, 16'h0002);
        send(8'h11);
        chk_wr("t2_b0", 16'hFFF, 8'h11);
        send(8'h22);
        chk_wr("t2_wrap", 16'h000, 8'h22);
        hdr(16'h0123, 16'h0000);
        idle(2);
        chk("t2_len0_we_cnt", 16'(we_cnt), 16'd5);
        chk("t2_len0_state", 16'(dut.state), 16'h0);

        // 3: swap request, double swap error, ack, status readback
        send(8'hC0);
        chk("t3_swap_req", 16'(bus.swap_req), 16'h1);
        chk("t3_err0", 16'(bus.err), 16'h0);
        send(8'hC0);
        chk("t3_dbl_swap_err", 16'(bus.err), 16'h1);
        ack_pulse();
        chk("t3_ack_clr", 16'(bus.swap_req), 16'h0);
        send(8'h80);
        chk("t3_status", 16'(bus.smi_out), 16'h40);
        rd_pulse();
        chk("t3_frame_cnt", 16'(bus.smi_out), 16'h01);
        rd_pulse();
        chk("t3_zero", 16'(bus.smi_out), 16'h00);
        chk("t3_state", 16'(dut.state), 16'h0);
        send(8'h01);
        chk("t3_err_clr", 16'(bus.err), 16'h0);
        ack_pulse();
        send(8'h80);
        chk("t3_status_clean", 16'(bus.smi_out), 16'h00);
        rd_pulse();
        chk("t3_stray_ack", 16'(bus.smi_out), 16'h01);
        rd_pulse();

        // 4: timeout inside a partial header
        send(8'h40);
        send(8'h00);
        idle(TIMEOUT - 1);
        chk("t4_pre_tmo_err", 16'(bus.err), 16'h0);
        chk("t4_pre_tmo_state", 16'(dut.state), 16'h2);
        idle(1);
        chk("t4_tmo_err", 16'(bus.err), 16'h1);
        chk("t4_tmo_state", 16'(dut.state), 16'h0);
        send(8'h80);
        chk("t4_status", 16'(bus.smi_out), 16'h40);
        rd_pulse();
        rd_pulse();
        send(8'h01);
        chk("t4_err_clr", 16'(bus.err), 16'h0);

        // 5: read and write together, then an illegal command
        @(negedge clk);
        bus.smi_in = 8'h00;
        bus.write  = 1'b1;
        bus.read   = 1'b1;
        @(negedge clk);
        bus.write  = 1'b0;
        bus.read   = 1'b0;
        chk("t5_rdwr_err", 16'(bus.err), 16'h1);
        chk("t5_rdwr_state", 16'(dut.state), 16'h0);
        send(8'h55);
        chk("t5_bad_cmd_err", 16'(bus.err), 16'h1);
        chk("t5_bad_cmd_state", 16'(dut.state), 16'h0);

        // 6: reset mid-burst with swap_req and err set
        send(8'hC0);
        hdr(16'h0100, 16'h0005);
        send(8'h01);
        chk_wr("t6_b0", 16'h100, 8'h01);
        send(8'h02);
        chk_wr("t6_b1", 16'h101, 8'h02);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_we", 16'(bus.fb_we), 16'h0);
        chk("t6_rst_addr", 16'(bus.fb_addr), 16'h000);
        chk("t6_rst_wdata", 16'(bus.fb_wdata), 16'h00);
        chk("t6_rst_swap_req", 16'(bus.swap_req), 16'h0);
        chk("t6_rst_err", 16'(bus.err), 16'h0);
        chk("t6_rst_state", 16'(dut.state), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;
        hdr(16'h0234, 16'h0001);
        send(8'h9A);
        chk_wr("t6_after", 16'h234, 8'h9A);
        idle(1);
        chk("t6_after_state", 16'(dut.state), 16'h0);
        send(8'h80);
        chk("t6_status", 16'(bus.smi_out), 16'h00);
        rd_pulse();
        chk("t6_frame_cnt_rst", 16'(bus.smi_out), 16'h00);
        rd_pulse();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
